// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - fetch, load-store and byte-memory bus bundle for mem_ctrl
interface mem_ctrl_if #(
   parameter int ADDR_WIDTH = 32
);
   // byte-wide RAM/IO port
   logic [7:0]            mem_din;
   logic [7:0]            mem_dout;
   logic [ADDR_WIDTH-1:0] mem_a;
   logic                  mem_wr;
   // instruction fetch channel
   logic                  if_req;
   logic [ADDR_WIDTH-1:0] if_addr;
   logic                  if_done;
   logic [31:0]           if_data;
   // load-store buffer channel
   logic                  lsb_req;
   logic                  lsb_wr;
   logic [1:0]            lsb_size;
   logic [ADDR_WIDTH-1:0] lsb_addr;
   logic [31:0]           lsb_wdata;
   logic                  lsb_done;
   logic [31:0]           lsb_rdata;

   // requester / memory side: the pipeline units plus the RAM model
   modport master (
      output mem_din, if_req, if_addr, lsb_req, lsb_wr, lsb_size, lsb_addr, lsb_wdata,
      input  mem_dout, mem_a, mem_wr, if_done, if_data, lsb_done, lsb_rdata
   );

   // controller side
   modport slave (
      input  mem_din, if_req, if_addr, lsb_req, lsb_wr, lsb_size, lsb_addr, lsb_wdata,
      output mem_dout, mem_a, mem_wr, if_done, if_data, lsb_done, lsb_rdata
   );
endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial arbiter/sequencer between IF, LSB and the 8-bit memory port
module mem_ctrl #(
   parameter int ADDR_WIDTH   = 32,
   parameter bit LSB_PRIORITY = 1'b1
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       rdy_in,
   input  logic       clear,
   input  logic       io_buffer_full,
   mem_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, IF_RD, LSB_RD, LSB_WR} state_t;

   state_t                state_q, state_d;
   logic [1:0]            cnt_q, cnt_d;
   logic [2:0]            n_q, n_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [31:0]           rbuf_q, rbuf_d;
   logic [31:0]           if_data_q, if_data_d;
   logic [31:0]           lsb_rdata_q, lsb_rdata_d;
   logic [7:0]            dout_q, dout_d;
   logic                  wr_q, wr_d;
   logic                  if_done_q, if_done_d;
   logic                  lsb_done_q, lsb_done_d;

   // request qualification and arbitration
   logic       io_block, if_ok, lsb_ok, take_lsb, take_if;
   logic [2:0] lsb_n, cnt_nx;
   logic       more;

   assign io_block = bus.lsb_wr && (bus.lsb_addr[17:16] == 2'b11) && io_buffer_full;
   assign if_ok    = bus.if_req && !if_done_q && !clear;
   assign lsb_ok   = bus.lsb_req && !lsb_done_q && !io_block;
   assign take_lsb = lsb_ok && (LSB_PRIORITY || !if_ok);
   assign take_if  = if_ok && !take_lsb;
   assign lsb_n    = (bus.lsb_size == 2'd0) ? 3'd1 : (bus.lsb_size == 2'd1) ? 3'd2 : 3'd4;
   assign cnt_nx   = {1'b0, cnt_q} + 3'd1;
   assign more     = (cnt_nx < n_q);

   // next-state and next-output logic for the byte sequencer
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      n_d         = n_q;
      base_d      = base_q;
      mem_a_d     = mem_a_q;
      wdata_d     = wdata_q;
      rbuf_d      = rbuf_q;
      if_data_d   = if_data_q;
      lsb_rdata_d = lsb_rdata_q;
      dout_d      = dout_q;
      wr_d        = wr_q;
      if_done_d   = 1'b0;
      lsb_done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (take_lsb) begin
               base_d  = bus.lsb_addr;
               mem_a_d = bus.lsb_addr;
               n_d     = lsb_n;
               wdata_d = bus.lsb_wdata;
               cnt_d   = 2'd0;
               rbuf_d  = 32'd0;
               if (bus.lsb_wr) begin
                  state_d = LSB_WR;
                  wr_d    = 1'b1;
                  dout_d  = bus.lsb_wdata[7:0];
               end else begin
                  state_d = LSB_RD;
               end
            end else if (take_if) begin
               base_d  = bus.if_addr;
               mem_a_d = bus.if_addr;
               n_d     = 3'd4;
               cnt_d   = 2'd0;
               rbuf_d  = 32'd0;
               state_d = IF_RD;
            end
         end
         IF_RD, LSB_RD: begin
            if (state_q == IF_RD && clear) begin
               // flushed fetch: drop partial bytes, no completion
               state_d = IDLE;
               cnt_d   = 2'd0;
               mem_a_d = '0;
            end else begin
               rbuf_d[{cnt_q, 3'b000} +: 8] = bus.mem_din;
               if (more) begin
                  cnt_d   = cnt_nx[1:0];
                  mem_a_d = base_q + ADDR_WIDTH'(cnt_nx);
               end else begin
                  state_d = IDLE;
                  cnt_d   = 2'd0;
                  mem_a_d = '0;
                  if (state_q == IF_RD) begin
                     if_done_d = 1'b1;
                     if_data_d = rbuf_d;
                  end else begin
                     lsb_done_d  = 1'b1;
                     lsb_rdata_d = rbuf_d;
                  end
               end
            end
         end
         LSB_WR: begin
            if (more) begin
               cnt_d   = cnt_nx[1:0];
               mem_a_d = base_q + ADDR_WIDTH'(cnt_nx);
               dout_d  = wdata_q[{cnt_nx[1:0], 3'b000} +: 8];
            end else begin
               state_d    = IDLE;
               cnt_d      = 2'd0;
               mem_a_d    = '0;
               wr_d       = 1'b0;
               lsb_done_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state register; everything freezes while rdy_in is low
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q     <= IDLE;
         cnt_q       <= 2'd0;
         n_q         <= 3'd0;
         base_q      <= '0;
         mem_a_q     <= '0;
         wdata_q     <= 32'd0;
         rbuf_q      <= 32'd0;
         if_data_q   <= 32'd0;
         lsb_rdata_q <= 32'd0;
         dout_q      <= 8'd0;
         wr_q        <= 1'b0;
         if_done_q   <= 1'b0;
         lsb_done_q  <= 1'b0;
      end else if (rdy_in) begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         n_q         <= n_d;
         base_q      <= base_d;
         mem_a_q     <= mem_a_d;
         wdata_q     <= wdata_d;
         rbuf_q      <= rbuf_d;
         if_data_q   <= if_data_d;
         lsb_rdata_q <= lsb_rdata_d;
         dout_q      <= dout_d;
         wr_q        <= wr_d;
         if_done_q   <= if_done_d;
         lsb_done_q  <= lsb_done_d;
      end
   end

   // write strobe is gated so a paused cycle never repeats a byte write
   assign bus.mem_a     = mem_a_q;
   assign bus.mem_dout  = dout_q;
   assign bus.mem_wr    = wr_q & rdy_in;
   assign bus.if_done   = if_done_q;
   assign bus.if_data   = if_data_q;
   assign bus.lsb_done  = lsb_done_q;
   assign bus.lsb_rdata = lsb_rdata_q;

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
mem_ctrl is the byte-serial memory arbiter and sequencer between the CPU pipeline and the single 8-bit RAM/IO port.
- It accepts word instruction-fetch requests from the fetch unit and 1/2/4-byte load/store requests from the load-store buffer.
- It serialises each request into byte accesses on mem_a/mem_dout/mem_wr and reassembles read bytes little-endian.
- It replaces the combinational IF/LSB bus mux in the cpu top, adding arbitration, clear handling, rdy_in pausing and UART back-pressure.

Parameters:
- ADDR_WIDTH, 32: width of all address ports.
- LSB_PRIORITY, 1: 1 means the LSB wins over IF when both request in the same cycle; 0 means IF wins.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  asynchronous active-high reset.
- rdy_in  in  1  when low, freeze all state.
- clear  in  1  pipeline flush (branch mispredict).
- io_buffer_full  in  1  UART tx buffer full.
- mem_din  in  8  RAM/IO read data, valid the cycle after its address.
- mem_dout  out  8  write data byte.
- mem_a  out  ADDR_WIDTH  byte address.
- mem_wr  out  1  1 means write.
- if_req  in  1  fetch request; level, held until if_done.
- if_addr  in  ADDR_WIDTH  fetch address.
- if_done  out  1  one-cycle pulse; if_data valid.
- if_data  out  32  fetched instruction.
- lsb_req  in  1  LSB request; level, held until lsb_done.
- lsb_wr  in  1  1 means store.
- lsb_size  in  2  0=byte, 1=half, 2=word.
- lsb_addr  in  ADDR_WIDTH  start address.
- lsb_wdata  in  32  store data, low bytes used.
- lsb_done  out  1  one-cycle pulse.
- lsb_rdata  out  32  load data, zero-extended; sign extension is done by the LSB.

Behaviour:
- Reset (async): state=IDLE, cnt=0, mem_a=0, mem_dout=0, mem_wr=0, if_done=0, lsb_done=0, if_data=0, lsb_rdata=0.
- rdy_in=0: no register changes. The output mem_wr is mem_wr_q AND rdy_in, so a write is never repeated while paused.
- States: IDLE, IF_RD, LSB_RD, LSB_WR. n = 4 for IF; for the LSB, n = 1 << lsb_size (lsb_size=3 is treated as 2).
- IDLE accept rule:
  - Requests are sampled at a clock edge and ignored if the corresponding done is high that cycle (one bubble cycle after every completion).
  - If both requests are eligible, LSB_PRIORITY decides.
  - On accept: latch base address, n, and wdata; set mem_a=base; cnt=0.
- Read (IF_RD/LSB_RD):
  - At each edge after acceptance, capture mem_din into byte lane cnt, increment cnt, and set mem_a=base+cnt+1 while cnt+1<n.
  - The edge that captures byte n-1 pulses the done signal (visible the next cycle) with assembled data, drives mem_a=0, and returns to IDLE.
  - Latency: done is high n+1 cycles after the accept edge's cycle (word fetch: accept at edge E0, if_done high in the cycle after E4).
- Write (LSB_WR):
  - On accept: mem_wr=1, mem_dout=wdata[7:0], mem_a=base.
  - At each following edge, advance to byte cnt+1 and address base+cnt+1.
  - After byte n-1 has been driven for one cycle: mem_wr=0, lsb_done pulses, return to IDLE.
  - A store of n bytes holds mem_wr high for exactly n cycles.
- IO back-pressure: an LSB store with lsb_addr[17:16]==2'b11 is not accepted while io_buffer_full=1. It stays pending and IF may be served meanwhile, subject to priority and eligibility.
- clear:
  - In IF_RD: abort to IDLE at that edge, mem_a=0, no if_done, partial data discarded.
  - In IDLE with if_req: the fetch is not accepted that edge.
  - LSB transactions are never aborted; lsb_done is still issued.
- Addresses are incremented in ADDR_WIDTH arithmetic, so wrap-around is modulo 2^ADDR_WIDTH. Misaligned accesses are legal and simply byte-sequential.
- Done pulses last exactly one cycle. if_data and lsb_rdata hold their values until the next completion.

Test Plan:
- Word fetch: RAM[0x100..0x103]=13,05,00,00; if_req, if_addr=0x100 → mem_a 0x100..0x103 in consecutive cycles, if_done once, if_data=0x00000513, mem_wr never 1.
- Simultaneous requests, LSB_PRIORITY=1: if_req and lsb_req (load half at 0x2002, RAM=0xAB,0xCD) at the same edge → lsb_done first with lsb_rdata=0x0000CDAB; the IF request is then served after a one-cycle bubble.
- Store word 0xDEADBEEF at 0x400 → mem_wr=1 for 4 cycles with mem_a/mem_dout pairs 0x400/EF, 0x401/BE, 0x402/AD, 0x403/DE, then one lsb_done.
- UART stall: io_buffer_full=1, byte store 0x41 to 0x30000 → no mem_wr for 5 cycles; deassert io_buffer_full → single write of 0x41 to 0x30000, lsb_done.
- clear mid-fetch: clear after 2 bytes of a fetch at 0x200 → IDLE, no if_done, a new fetch at 0x300 completes correctly; clear during an LSB load → load still completes.
- Pause and reset: rdy_in=0 for 3 cycles mid-store → mem_wr=0 while paused, no duplicated or skipped bytes; rst_in asserted mid-read → all outputs 0 immediately (async), state IDLE.
